rx_frame_ctrl: RTL
==================

// Module: rx_frame_ctrl
// PURPOSE
//   Sequences the UART receive byte buffer. Collects FRAME_LEN bytes from the UART
//   receiver into the buffer, drives the buffer's write strobe, data and address,
//   then holds the complete frame for the consumer under a valid/ack handshake.
//   Discards partial frames after an inter-byte timeout. Flags bytes arriving while
//   a frame is pending. Sits between the UART RX core and the buffer/CPU read side.
// PARAMETERS
//   FRAME_LEN  5      bytes per frame (1..7)
//   DATA_W     8      byte width
//   ADDR_W     3      buffer address width
//   TO_CYCLES  50000  max idle clocks between bytes of one frame (>=2)
//   TO_W       16     timeout counter width
// PORTS
//   clk           in   1       system clock, all logic on rising edge
//   reset         in   1       synchronous, active-high reset
//   rx_done_tick  in   1       1-cycle pulse: rx_dout holds a new byte
//   rx_dout       in   DATA_W  received byte
//   buf_wr        out  1       buffer write strobe (1-cycle pulse)
//   buf_w_data    out  DATA_W  buffer write data
//   buf_addr      out  ADDR_W  buffer address (write index, or rd_addr in READY)
//   rd_addr       in   ADDR_W  consumer read index
//   frame_valid   out  1       complete frame held in buffer
//   frame_ack     in   1       consumer done with frame (sampled only in READY)
//   byte_cnt      out  ADDR_W  bytes stored in current frame
//   overrun       out  1       1-cycle pulse: byte dropped, frame pending
//   timeout_err   out  1       1-cycle pulse: partial frame discarded
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; counters 0. Buffer contents untouched.
//     Reset mid-frame discards the partial frame.
//   States: IDLE -> COLLECT -> COMMIT -> READY -> IDLE/COLLECT.
//   Write: rx_done_tick in cycle n => buf_wr=1, buf_w_data=rx_dout,
//     buf_addr=byte_cnt(old) in cycle n+1; byte_cnt increments in n+1.
//   IDLE: rx_done_tick => write at addr 0, byte_cnt=1 -> COLLECT
//     (-> COMMIT if FRAME_LEN==1).
//   COLLECT: rx_done_tick => write at byte_cnt, byte_cnt+1. If that write is
//     byte FRAME_LEN-1 -> COMMIT. Timeout counter clears on every accepted byte
//     and increments otherwise. Reaching TO_CYCLES => timeout_err pulse,
//     byte_cnt=0, no write -> IDLE.
//   COMMIT: single cycle; frame_valid rises one cycle after the final buf_wr.
//     rx_done_tick here => overrun.
//   READY: frame_valid=1, byte_cnt=FRAME_LEN. buf_addr=rd_addr (combinational);
//     rd_addr>=FRAME_LEN gives buf_addr=0. rx_done_tick without ack => overrun
//     pulse next cycle, byte dropped, no buf_wr.
//     frame_ack => frame_valid=0 next cycle, byte_cnt=0 -> IDLE.
//     frame_ack with rx_done_tick in the same cycle: ack wins. The byte is
//     written at addr 0, byte_cnt=1, no overrun -> COLLECT.
//   Outside READY: buf_addr = last write index; frame_ack ignored.
//   buf_wr is never high for 2 consecutive cycles.
//   No timeout in IDLE, COMMIT or READY.
// TESTING
//   5 rx ticks (0x11..0x55) 3 clk apart -> buf_wr pulses at addr 0..4 with those
//     data; frame_valid=1 one cycle after the 5th pulse; byte_cnt=5.
//   In READY, rd_addr=2 -> buf_addr=2 same cycle. rd_addr=6 -> buf_addr=0.
//   READY, rx tick 0x99 without ack -> overrun 1-cycle pulse, no buf_wr,
//     frame_valid stays 1.
//   READY, frame_ack and rx tick 0xA0 same cycle -> frame_valid=0,
//     buf_wr at addr 0 data 0xA0, byte_cnt=1, state COLLECT.
//   2 bytes, then TO_CYCLES=20 idle clocks -> timeout_err pulse, byte_cnt=0;
//     next byte is written at addr 0.
//   reset after 3 bytes -> all outputs 0; 5 new bytes form a full frame at addr 0..4.

Source files
------------

// File: rtl/rx_frame_ctrl_if.sv
// Byte-buffer side of the UART receive sequencer: RX core inputs, buffer write
// port and the consumer's valid/ack read handshake.
interface rx_frame_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              rx_done_tick;
  logic [DATA_W-1:0] rx_dout;
  logic              buf_wr;
  logic [DATA_W-1:0] buf_w_data;
  logic [ADDR_W-1:0] buf_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              frame_valid;
  logic              frame_ack;
  logic [ADDR_W-1:0] byte_cnt;
  logic              overrun;
  logic              timeout_err;

  // The controller itself
  modport master (
    input  rx_done_tick, rx_dout, rd_addr, frame_ack,
    output buf_wr, buf_w_data, buf_addr, frame_valid, byte_cnt, overrun, timeout_err
  );

  // RX core, buffer and consumer as seen from outside the controller
  modport slave (
    output rx_done_tick, rx_dout, rd_addr, frame_ack,
    input  buf_wr, buf_w_data, buf_addr, frame_valid, byte_cnt, overrun, timeout_err
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Collects FRAME_LEN received bytes into the byte buffer, then holds the frame
// for the consumer until it acknowledges; stalled partial frames are discarded.
module rx_frame_ctrl #(
  parameter int FRAME_LEN = 5,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int TO_CYCLES = 50000,
  parameter int TO_W      = 16
) (
  input logic          clk,
  input logic          reset,
  rx_frame_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_LEN);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYCLES - 1);

  state_t            state_q, state_d;
  logic              buf_wr_q, buf_wr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic              take_byte;
  logic              timeout_hit;
  logic [ADDR_W-1:0] wr_idx;
  logic              last_byte;

  // A tick right after a write is dropped so buf_wr can never stay high twice.
  assign take_byte   = bus.rx_done_tick && !buf_wr_q &&
                       ((state_q == IDLE) || (state_q == COLLECT) ||
                        ((state_q == READY) && bus.frame_ack));
  assign timeout_hit = (state_q == COLLECT) && !take_byte && (to_cnt_q == TO_LAST);
  assign wr_idx      = (state_q == COLLECT) ? byte_cnt_q : '0;
  assign last_byte   = (wr_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_wr_q      <= 1'b0;
      w_data_q      <= '0;
      w_addr_q      <= '0;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_wr_q      <= buf_wr_d;
      w_data_q      <= w_data_d;
      w_addr_q      <= w_addr_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_byte) state_d = last_byte ? COMMIT : COLLECT;
      COLLECT: begin
        if (timeout_hit)    state_d = IDLE;
        else if (take_byte) state_d = last_byte ? COMMIT : COLLECT;
      end
      COMMIT:  state_d = READY;
      READY: begin
        if (bus.frame_ack) begin
          if (take_byte) state_d = last_byte ? COMMIT : COLLECT;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_wr_d      = 1'b0;
    w_data_d      = w_data_q;
    w_addr_d      = w_addr_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = '0;
    frame_valid_d = (state_d == READY);
    overrun_d     = 1'b0;
    timeout_d     = 1'b0;

    if (take_byte) begin
      buf_wr_d   = 1'b1;
      w_data_d   = bus.rx_dout;
      w_addr_d   = wr_idx;
      byte_cnt_d = wr_idx + ADDR_W'(1);
    end

    case (state_q)
      COLLECT: begin
        if (timeout_hit) begin
          timeout_d  = 1'b1;
          byte_cnt_d = '0;
        end else if (!take_byte) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      COMMIT: overrun_d = bus.rx_done_tick;
      READY: begin
        if (bus.frame_ack && !take_byte) byte_cnt_d = '0;
        overrun_d = bus.rx_done_tick && !bus.frame_ack;
      end
      default: ;
    endcase
  end

  // While a frame is held the consumer steers the buffer address; out-of-frame indices read slot 0.
  always_comb begin
    bus.buf_addr = w_addr_q;
    if (state_q == READY)
      bus.buf_addr = (bus.rd_addr < FRAME_CNT) ? bus.rd_addr : '0;
  end

  assign bus.buf_wr      = buf_wr_q;
  assign bus.buf_w_data  = w_data_q;
  assign bus.byte_cnt    = (state_q == READY) ? FRAME_CNT : byte_cnt_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;

endmodule
